dma_writer: RTL and testbench
=============================

Name: dma_writer

Overview:
Downstream consumer of the parser output FIFO. Pops 32-bit parsed words from the FIFO and writes them to a contiguous, word-addressed memory region over a valid/ready write interface. Groups beats into fixed-length bursts, flagged with mem_last. One transfer runs per start pulse; done is pulsed on completion.

Parameters:
WIDTH, 32, data word width; matches the FIFO WIDTH.
ADDR_W, 16, memory word-address width.
LEN_W, 16, width of the transfer length in words.
BURST_LEN, 4, beats per burst; power of two, at least 1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; latches cfg_addr and cfg_len
cfg_addr  in  ADDR_W  first word address
cfg_len  in  LEN_W  number of words to transfer
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
fifo_rd_en  out  1  FIFO pop request
fifo_rdata  in  WIDTH  FIFO read data; valid the cycle after a pop
fifo_empty  in  1  FIFO empty flag; combinational
mem_valid  out  1  write beat valid
mem_ready  in  1  memory accepts the beat
mem_addr  out  ADDR_W  beat word address
mem_wdata  out  WIDTH  beat data
mem_last  out  1  last beat of the burst
csum  out  WIDTH  running XOR checksum (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; all internal registers 0.
- States: IDLE, POP, CAP, WRITE, DONE.
- IDLE:
  - On start with cfg_len != 0: latch addr_r = cfg_addr, rem = cfg_len, beat_cnt = 0; go to POP.
  - On start with cfg_len == 0: go to DONE; the FIFO is never read.
  - start is ignored in every state except IDLE.
- POP:
  - fifo_rd_en = (state == POP) && !fifo_empty. This is Mealy logic and is never asserted while fifo_empty.
  - When fifo_rd_en is high, go to CAP. Otherwise stay in POP indefinitely; there is no timeout.
- CAP:
  - fifo_rdata is valid this cycle. Register it into mem_wdata; go to WRITE.
- WRITE:
  - mem_valid = 1. mem_addr = addr_r. mem_last = (beat_cnt == BURST_LEN-1) || (rem == 1).
  - mem_addr, mem_wdata and mem_last are held stable until mem_ready.
  - On mem_valid && mem_ready:
    - addr_r increments by 1 and wraps modulo 2^ADDR_W.
    - rem decrements by 1.
    - beat_cnt increments, or resets to 0 when mem_last is high.
    - If rem was 1, go to DONE; otherwise go to POP.
- DONE: done = 1 for exactly one cycle; busy = 0; return to IDLE.
- busy = 1 in POP, CAP and WRITE.
- Minimum cost is 3 cycles per word (POP, CAP, WRITE) with the FIFO non-empty and mem_ready held high.
- A short final burst (rem reaches 1 with beat_cnt < BURST_LEN-1) asserts mem_last on that beat.
- mem_ready while mem_valid is low is ignored.
- Reset mid-transfer: everything returns asynchronously to reset values. A beat in flight is dropped and no done pulse is issued.

Optional Feature:
- Macro: DMA_WRITER_CSUM_EN.
- Defined:
  - csum clears to 0 on an accepted start.
  - csum XORs in mem_wdata on each accepted beat.
  - csum holds its final value from the DONE cycle until the next start.
- Undefined: csum is tied to 0 and no checksum logic is built.

Decomposition:
- Package dma_writer_pkg holds:
  - state_t enum (IDLE, POP, CAP, WRITE, DONE);
  - default-width localparams.
- Sub-module dma_burst_tracker holds addr_r, rem and beat_cnt. Its outputs are mem_addr, mem_last and last_word, advanced by a single beat_accept input.

Test Plan:
- FIFO preloaded with 0xA0..0xA5; start, cfg_addr = 0x0100, cfg_len = 6, mem_ready = 1 → beats at addresses 0x100..0x105 with data A0..A5. mem_last is high on the 4th and 6th beats. done pulses once, 18 cycles after busy rises.
- FIFO empty at start; push one word 20 cycles later → fifo_rd_en stays low while empty. The transfer then completes with done and exactly one beat.
- mem_ready low for 5 cycles during WRITE → mem_valid, mem_addr and mem_wdata are held unchanged. Exactly one beat is accepted and rem decrements only once.
- cfg_addr = 0xFFFE, cfg_len = 4 → beat addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- cfg_len = 0 → no fifo_rd_en; done pulses 1 cycle after start. A start pulsed while busy is ignored.
- Reset asserted in WRITE → all outputs 0 immediately and no done pulse. A new transfer afterwards runs correctly. With DMA_WRITER_CSUM_EN, data 0x1,0x2,0x4 gives csum = 0x7.

Source files
------------

// File: rtl/dma_writer_pkg.sv
// Shared types and default sizes for the DMA writer slice.
// Holds the FSM state encoding and a counter-width helper.
package dma_writer_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int ADDR_W_DEF    = 16;
    localparam int LEN_W_DEF     = 16;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAP,
        WRITE,
        DONE
    } state_t;

    // Width of a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_burst_tracker.sv
// Address, remaining-word and in-burst beat tracking for dma_writer.
// Ports: clk, rst (async, active-low), load_i/cfg_addr_i/cfg_len_i
// start a transfer, beat_accept_i advances one beat; mem_addr_o is
// the current beat address, mem_last_o flags the last beat of a burst
// (or of the transfer), last_word_o is high when one word remains.
module dma_burst_tracker
    import dma_writer_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              beat_accept_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_last_o,
    output logic              last_word_o
);

    localparam int CNT_W = cnt_w(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign last_word_o = (rem_q == LEN_W'(1));
    assign mem_last_o  = (cnt_q == CNT_MAX) || last_word_o;
    assign mem_addr_o  = addr_q;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = cfg_addr_i;
            rem_d  = cfg_len_i;
            cnt_d  = '0;
        end else if (beat_accept_i) begin
            // Address wraps naturally at the register width.
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            cnt_d  = mem_last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_writer.sv
// FIFO-to-memory burst writer: pops parsed words and writes them to a
// contiguous word-addressed region, one transfer per start pulse.
// Ports: clk, rst (async, active-low); start/cfg_addr/cfg_len launch a
// transfer; busy/done report status; fifo_rd_en/fifo_rdata/fifo_empty
// drain the FIFO; mem_valid/mem_ready/mem_addr/mem_wdata/mem_last form
// the write beat interface; csum is the XOR checksum of written data.
// Build option: define DMA_WRITER_CSUM_EN to build the checksum,
// otherwise csum is tied to zero.
module dma_writer
    import dma_writer_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd_en,
    input  logic [WIDTH-1:0]  fifo_rdata,
    input  logic              fifo_empty,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_last,
    output logic [WIDTH-1:0]  csum
);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [WIDTH-1:0]  wdata_q;

    logic              start_ok;
    logic              load;
    logic              beat_accept;
    logic              last_raw;
    logic              last_word;

    // start only counts while idle; a zero length skips the FIFO.
    assign start_ok    = (state_q == IDLE) && start;
    assign load        = start_ok && (cfg_len != '0);
    assign beat_accept = valid_q && mem_ready;

    // Pop request is combinational so it never fires on an empty FIFO.
    assign fifo_rd_en = (state_q == POP) && !fifo_empty;

    dma_burst_tracker #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .BURST_LEN (BURST_LEN)
    ) u_trk (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load),
        .cfg_addr_i    (cfg_addr),
        .cfg_len_i     (cfg_len),
        .beat_accept_i (beat_accept),
        .mem_addr_o    (mem_addr),
        .mem_last_o    (last_raw),
        .last_word_o   (last_word)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_valid = valid_q;
    assign mem_wdata = wdata_q;
    // Qualified so the flag stays low outside a live beat.
    assign mem_last  = valid_q && last_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (load) begin
                            state_q <= POP;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                POP: begin
                    if (fifo_rd_en) begin
                        state_q <= CAP;
                    end
                end
                CAP: begin
                    wdata_q <= fifo_rdata;
                    valid_q <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (beat_accept) begin
                        valid_q <= 1'b0;
                        if (last_word) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= POP;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMA_WRITER_CSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (beat_accept) begin
            csum_d = csum_q ^ wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_dma_writer.sv
// Self-checking bench for dma_writer: table vectors, corner sequences
// and randomized transfers against a queue-based reference model.
module tb_dma_writer;

    localparam int BL = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_addr;
    logic [15:0] cfg_len;
    logic        busy;
    logic        done;
    logic        fifo_rd_en;
    logic [31:0] fifo_rdata;
    logic        fifo_empty;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_last;
    logic [31:0] csum;

    dma_writer #(
        .WIDTH     (32),
        .ADDR_W    (16),
        .LEN_W     (16),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_addr   (cfg_addr),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_last   (mem_last),
        .csum       (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] addr;
        int          len;
        logic [31:0] base;
        int          exp_lasts;
        logic [15:0] exp_end;
        int          exp_busy;
    } vec_t;

    beat_t       got_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] ed[$];
    vec_t        vt[5];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int rdempty_cnt = 0;
    bit stop;

    // FIFO model: pops and pushes resolve on the clock edge only.
    always @(posedge clk) begin
        if (!rst) begin
            fifo_q.delete();
            fifo_rdata <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fifo_q.size() > 0)
                fifo_rdata <= fifo_q.pop_front();
            while (pend_q.size() > 0)
                fifo_q.push_back(pend_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (mem_valid && mem_ready)
                got_q.push_back('{addr: mem_addr, data: mem_wdata,
                                  last: mem_last});
            if (done) done_cnt++;
            if (fifo_rd_en) rd_cnt++;
            if (fifo_rd_en && fifo_empty) rdempty_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        pend_q.push_back(w);
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] l);
        @(posedge clk);
        #2;
        start    = 1'b1;
        cfg_addr = a;
        cfg_len  = l;
        @(posedge clk);
        #2;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int nb, output bit to);
        nb = 0;
        to = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin
                to = 1'b0;
                break;
            end
            if (busy) nb++;
        end
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] d[$]);
        logic [31:0] x;
        x = '0;
        foreach (d[i]) x = x ^ d[i];
`ifdef DMA_WRITER_CSUM_EN
        return x;
`else
        return 32'h0;
`endif
    endfunction

    // Reference: word i lands at base+i (16-bit wrap), carries the
    // i-th FIFO word, and closes a burst every BL beats or at the end.
    task automatic check_beats(input string tag, input logic [15:0] a,
                               input int len, input logic [31:0] d[$]);
        logic [48:0] e;
        logic [48:0] g;
        int n;
        chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(len));
        n = (got_q.size() < len) ? got_q.size() : len;
        for (int i = 0; i < n; i++) begin
            e = {a + 16'(i), d[i],
                 ((i % BL) == BL - 1) || (i == len - 1)};
            g = {got_q[i].addr, got_q[i].data, got_q[i].last};
            chk({tag, "_beat"}, 64'(g), 64'(e));
        end
        got_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int nb;
        bit to;
        int d0;
        int r0;
        int lasts;
        logic [15:0] endaddr;
        logic [15:0] sa;
        logic [31:0] sd;
        logic [15:0] ra;
        int rl;

        #600000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        bit to;
        int d0;
        int r0;
        int lasts;
        logic [15:0] endaddr;
        logic [15:0] sa;
        logic [31:0] sd;
        logic [15:0] ra;
        int rl;

        vt[0] = '{16'h0100, 6, 32'h000000A0, 2, 16'h0105, 18};
        vt[1] = '{16'hFFFE, 4, 32'h11110000, 1, 16'h0001, 12};
        vt[2] = '{16'h0010, 1, 32'h22220000, 1, 16'h0010, 3};
        vt[3] = '{16'h0020, 8, 32'h33330000, 2, 16'h0027, 24};
        vt[4] = '{16'h0030, 5, 32'h44440000, 2, 16'h0034, 15};

        rst       = 1'b0;
        start     = 1'b0;
        cfg_addr  = '0;
        cfg_len   = '0;
        mem_ready = 1'b0;
        stop      = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({busy, done, fifo_rd_en, mem_valid, mem_last}),
            64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_csum", 64'(csum), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Table vectors: FIFO preloaded, memory always ready.
        mem_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            ed.delete();
            for (int i = 0; i < vt[v].len; i++) begin
                ed.push_back(vt[v].base + 32'(i));
                push_word(vt[v].base + 32'(i));
            end
            repeat (3) @(posedge clk);
            d0 = done_cnt;
            do_start(vt[v].addr, 16'(vt[v].len));
            wait_done(200, nb, to);
            chk("vec_timeout", 64'(to), 64'd0);
            chk("vec_busy_cycles", 64'(nb), 64'(vt[v].exp_busy));
            repeat (2) @(negedge clk);
            chk("vec_done_once", 64'(done_cnt - d0), 64'd1);
            chk("vec_busy_after", 64'(busy), 64'd0);
            lasts = 0;
            endaddr = 16'hDEAD;
            foreach (got_q[i]) if (got_q[i].last) lasts++;
            if (got_q.size() > 0)
                endaddr = got_q[got_q.size() - 1].addr;
            chk("vec_lasts", 64'(lasts), 64'(vt[v].exp_lasts));
            chk("vec_end_addr", 64'(endaddr), 64'(vt[v].exp_end));
            chk("vec_csum", 64'(csum), 64'(exp_csum(ed)));
            check_beats("vec", vt[v].addr, vt[v].len, ed);
        end

        // Empty FIFO at start: no pop until data shows up.
        r0 = rd_cnt;
        d0 = done_cnt;
        do_start(16'h0200, 16'd1);
        repeat (20) @(negedge clk);
        chk("empty_no_rden", 64'(rd_cnt - r0), 64'd0);
        chk("empty_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2;
        push_word(32'h5A5A0001);
        wait_done(100, nb, to);
        chk("empty_timeout", 64'(to), 64'd0);
        repeat (2) @(negedge clk);
        chk("empty_done_once", 64'(done_cnt - d0), 64'd1);
        ed.delete();
        ed.push_back(32'h5A5A0001);
        check_beats("empty", 16'h0200, 1, ed);

        // Write stall: beat held stable while mem_ready is low.
        mem_ready = 1'b0;
        ed.delete();
        ed.push_back(32'h000000B0);
        ed.push_back(32'h000000B1);
        push_word(ed[0]);
        push_word(ed[1]);
        repeat (3) @(posedge clk);
        do_start(16'h0300, 16'd2);
        wait_valid("stall");
        sa = mem_addr;
        sd = mem_wdata;
        chk("stall_addr", 64'(sa), 64'h0300);
        chk("stall_data", 64'(sd), 64'h000000B0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", 64'({mem_valid, mem_addr, mem_wdata}),
                64'({1'b1, sa, sd}));
        end
        chk("stall_no_beat", 64'(got_q.size()), 64'd0);
        @(posedge clk);
        #2;
        mem_ready = 1'b1;
        wait_done(100, nb, to);
        chk("stall_timeout", 64'(to), 64'd0);
        repeat (2) @(negedge clk);
        check_beats("stall", 16'h0300, 2, ed);

        // Zero length: straight to done, FIFO untouched.
        r0 = rd_cnt;
        d0 = done_cnt;
        do_start(16'h0400, 16'd0);
        wait_done(5, nb, to);
        chk("zero_timeout", 64'(to), 64'd0);
        chk("zero_busy_cycles", 64'(nb), 64'd0);
        repeat (2) @(negedge clk);
        chk("zero_no_rden", 64'(rd_cnt - r0), 64'd0);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);
        chk("zero_no_beat", 64'(got_q.size()), 64'd0);

        // start while busy is ignored.
        ed.delete();
        ed.push_back(32'h000000C0);
        ed.push_back(32'h000000C1);
        push_word(ed[0]);
        push_word(ed[1]);
        repeat (3) @(posedge clk);
        d0 = done_cnt;
        do_start(16'h0500, 16'd2);
        do_start(16'h0600, 16'd5);
        wait_done(100, nb, to);
        chk("busy_start_timeout", 64'(to), 64'd0);
        repeat (10) @(negedge clk);
        chk("busy_start_done", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_idle", 64'(busy), 64'd0);
        check_beats("busy_start", 16'h0500, 2, ed);

        // Reset while a beat waits in WRITE.
        mem_ready = 1'b0;
        push_word(32'h000000D0);
        repeat (3) @(posedge clk);
        do_start(16'h0700, 16'd3);
        wait_valid("rstw");
        d0 = done_cnt;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rstw_ctl", 64'({busy, done, fifo_rd_en, mem_valid, mem_last}),
            64'd0);
        chk("rstw_addr", 64'(mem_addr), 64'd0);
        chk("rstw_wdata", 64'(mem_wdata), 64'd0);
        chk("rstw_csum", 64'(csum), 64'd0);
        repeat (4) @(negedge clk);
        chk("rstw_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rstw_no_beat", 64'(got_q.size()), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        mem_ready = 1'b1;
        got_q.delete();

        // Recovery transfer; checksum of 1,2,4 is 7 when built.
        ed.delete();
        ed.push_back(32'h1);
        ed.push_back(32'h2);
        ed.push_back(32'h4);
        foreach (ed[i]) push_word(ed[i]);
        repeat (3) @(posedge clk);
        d0 = done_cnt;
        do_start(16'h0800, 16'd3);
        wait_done(100, nb, to);
        chk("post_rst_timeout", 64'(to), 64'd0);
        repeat (2) @(negedge clk);
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);
`ifdef DMA_WRITER_CSUM_EN
        chk("csum_147", 64'(csum), 64'h7);
`else
        chk("csum_off", 64'(csum), 64'h0);
`endif
        check_beats("post_rst", 16'h0800, 3, ed);

        // Randomized transfers with bursty FIFO and random ready.
        for (int t = 0; t < 25; t++) begin
            ra = 16'($urandom);
            rl = int'($urandom_range(1, 9));
            ed.delete();
            for (int i = 0; i < rl; i++) ed.push_back($urandom);
            d0 = done_cnt;
            stop = 1'b0;
            fork
                begin
                    for (int i = 0; i < rl; i++) begin
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        #2;
                        push_word(ed[i]);
                    end
                end
                begin
                    do_start(ra, 16'(rl));
                    wait_done(800, nb, to);
                    stop = 1'b1;
                end
                begin
                    while (!stop) begin
                        @(posedge clk);
                        #2;
                        if (!stop) mem_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            mem_ready = 1'b1;
            chk("rand_timeout", 64'(to), 64'd0);
            repeat (2) @(negedge clk);
            chk("rand_done_once", 64'(done_cnt - d0), 64'd1);
            chk("rand_csum", 64'(csum), 64'(exp_csum(ed)));
            check_beats("rand", ra, rl, ed);
            if (to) begin
                @(posedge clk);
                #2;
                rst = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                rst = 1'b1;
                got_q.delete();
            end
        end

        chk("rden_while_empty", 64'(rdempty_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
